// File: rtl/cache_types.sv
// Shared cache-coherence types: bus transaction encodings, request/response
// payloads and the snoop-bus arbiter state encoding.
package cache_types;

  localparam int unsigned NUM_CACHE = 8;
  localparam int unsigned SRC_W     = $clog2(NUM_CACHE) + 1;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    GETS = 2'd0,
    GETM = 2'd1,
    PUTM = 2'd2,
    UPGR = 2'd3
  } bus_tx_t;

  typedef struct packed {
    logic              valid;
    logic [SRC_W-1:0]  source;
    bus_tx_t           bus_tx;
    logic [ADDR_W-1:0] addr;
  } req_msg_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } resp_msg_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BCAST = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/coherence_bus_arbiter_if.sv
// Snoop-bus signal bundle between the cache requesters / responders (master)
// and the coherence bus arbiter (slave).
interface coherence_bus_arbiter_if
  import cache_types::*;
#(
  parameter int unsigned NUM_REQ = NUM_CACHE
) ();

  req_msg_t [NUM_REQ-1:0] req_msg;
  logic     [NUM_REQ-1:0] req_ready;
  req_msg_t               bus_req;
  resp_msg_t              resp_in;
  resp_msg_t              bus_resp;
  logic                   busy;
  logic                   timeout_err;

  modport master (
    output req_msg,
    output resp_in,
    input  req_ready,
    input  bus_req,
    input  bus_resp,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  req_msg,
    input  resp_in,
    output req_ready,
    output bus_req,
    output bus_resp,
    output busy,
    output timeout_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping from NUM_REQ-1 to 0.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_i;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    pos_i = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos = 32'(ptr) + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_i = IDX_W'(pos);
      if (!found && req[pos_i]) begin
        found        = 1'b1;
        grant[pos_i] = 1'b1;
        idx          = pos_i;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Atomic snoop-bus arbiter: round-robin grant, one-cycle broadcast, then wait
// for the address-matching response or abort after TIMEOUT_CYCLES wait cycles.
module coherence_bus_arbiter
  import cache_types::*;
#(
  parameter int unsigned NUM_REQ        = NUM_CACHE,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                    clk,
  input logic                    rst,
  coherence_bus_arbiter_if.slave bus
);

  localparam int unsigned      IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  req_msg_t         bus_req_q, bus_req_d;
  resp_msg_t        bus_resp_q, bus_resp_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               resp_match;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) req_valid[i] = bus.req_msg[i].valid;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .found (grant_any)
  );

  // bus_req_q keeps the granted address after the broadcast for completion matching
  assign resp_match = bus.resp_in.valid && (bus.resp_in.addr == bus_req_q.addr);

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    wait_cnt_d      = wait_cnt_q;
    bus_req_d       = bus_req_q;
    bus_req_d.valid = 1'b0;
    bus_resp_d      = bus.resp_in;
    timeout_err_d   = 1'b0;
    req_ready_c     = '0;

    case (state_q)
      ARB_IDLE: begin
        if (grant_any) begin
          req_ready_c      = grant;
          bus_req_d        = bus.req_msg[grant_idx];
          bus_req_d.valid  = 1'b1;
          bus_req_d.source = SRC_W'(grant_idx);
          rr_ptr_d         = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
          state_d          = ARB_BCAST;
        end
      end
      ARB_BCAST: begin
        wait_cnt_d = '0;
        state_d    = ARB_WAIT;
      end
      ARB_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (resp_match) begin
          state_d = ARB_IDLE;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d       = ARB_IDLE;
          timeout_err_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      rr_ptr_q      <= '0;
      wait_cnt_q    <= '0;
      bus_req_q     <= '0;
      bus_resp_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      wait_cnt_q    <= wait_cnt_d;
      bus_req_q     <= bus_req_d;
      bus_resp_q    <= bus_resp_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Accept pulse is combinational so the requester can drop valid in the grant cycle
  assign bus.req_ready   = rst ? '0 : req_ready_c;
  assign bus.bus_req     = bus_req_q;
  assign bus.bus_resp    = bus_resp_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed protocol scenarios followed by random traffic, all checked each cycle
// against a transaction-level model of the snoop-bus arbiter.
module tb_coherence_bus_arbiter;
  import cache_types::*;

  localparam int unsigned N  = NUM_CACHE;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned TO = 12;

  logic clk;
  logic rst;

  coherence_bus_arbiter_if #(.NUM_REQ(N)) bus_if ();

  coherence_bus_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: at most one transaction, aged in cycles since its grant
  bit           m_busy;
  int           m_age;
  int           m_rr;
  int           m_src;
  req_msg_t     m_lat;
  resp_msg_t    m_prev_resp;
  bit           m_to;
  int           last_grant;
  logic [N-1:0] obs_ready;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[IW'(i)] = 1'b1;
    return v;
  endfunction

  function automatic int winner();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (bus_if.req_msg[IW'(j)].valid) return j;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    return {20'h0, 4'($urandom_range(0, 15)), 8'h0};
  endfunction

  task automatic set_req(input int i, input bit v, input bus_tx_t tx, input logic [31:0] a);
    req_msg_t m;
    m.valid  = v;
    m.source = SRC_W'($urandom);
    m.bus_tx = tx;
    m.addr   = a;
    bus_if.req_msg[IW'(i)] = m;
  endtask

  task automatic set_resp(input bit v, input logic [31:0] a);
    bus_if.resp_in.valid = v;
    bus_if.resp_in.addr  = a;
    bus_if.resp_in.data  = $urandom;
  endtask

  // Check one cycle at the falling edge, advance the model, return 1ns after the next rising edge
  task automatic step();
    int           w;
    logic [N-1:0] exp_ready;
    req_msg_t     exp_req;
    @(negedge clk);
    w         = (rst || m_busy) ? -1 : winner();
    exp_ready = (w >= 0) ? onehot(w) : '0;
    obs_ready = bus_if.req_ready;
    check("req_ready", 128'(bus_if.req_ready), 128'(exp_ready));
    check("busy", 128'(bus_if.busy), 128'(m_busy));
    check("timeout_err", 128'(bus_if.timeout_err), 128'(m_to));
    check("bus_resp", 128'(bus_if.bus_resp), 128'(m_prev_resp));
    if (m_busy && m_age == 1) begin
      exp_req        = m_lat;
      exp_req.valid  = 1'b1;
      exp_req.source = SRC_W'(m_src);
      check("bus_req", 128'(bus_if.bus_req), 128'(exp_req));
    end else begin
      check("bus_req_valid", 128'(bus_if.bus_req.valid), 128'(1'b0));
    end

    last_grant = w;
    if (rst) begin
      m_busy      = 1'b0;
      m_age       = 0;
      m_rr        = 0;
      m_to        = 1'b0;
      m_prev_resp = '0;
    end else begin
      m_to = 1'b0;
      if (!m_busy) begin
        if (w >= 0) begin
          m_lat  = bus_if.req_msg[IW'(w)];
          m_src  = w;
          m_rr   = (w + 1) % N;
          m_busy = 1'b1;
          m_age  = 1;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (bus_if.resp_in.valid && bus_if.resp_in.addr == m_lat.addr) begin
        m_busy = 1'b0;
      end else if (m_age - 1 == TO) begin
        m_busy = 1'b0;
        m_to   = 1'b1;
      end else begin
        m_age++;
      end
      m_prev_resp = bus_if.resp_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int idx, input logic [31:0] a, input string tag);
    set_req(idx, 1'b1, GETS, a);
    step();
    check(tag, 128'(obs_ready), 128'(onehot(idx)));
    set_req(idx, 1'b0, GETS, a);
    step();
    set_resp(1'b1, a);
    step();
    set_resp(1'b0, 32'h0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, GETS, 32'h0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    int first;

    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, GETS, 32'h0);
    set_resp(1'b0, 32'h0);
    m_busy = 1'b0; m_age = 0; m_rr = 0; m_src = 0; m_to = 1'b0;
    m_lat = '0; m_prev_resp = '0; last_grant = -1; obs_ready = '0;
    @(posedge clk);
    #1;
    step();
    step();
    check("rst_bus_req", 128'(bus_if.bus_req), 128'(0));
    check("rst_bus_resp", 128'(bus_if.bus_resp), 128'(0));

    // Single GETS from cache 3 with the response two cycles after the broadcast
    rst = 1'b0;
    set_req(3, 1'b1, GETS, 32'h100);
    step();
    check("s1_ready3", 128'(obs_ready), 128'(8'b0000_1000));
    check("s1_bcast_valid", 128'(bus_if.bus_req.valid), 128'(1'b1));
    check("s1_bcast_src", 128'(bus_if.bus_req.source), 128'(4'd3));
    check("s1_bcast_tx", 128'(bus_if.bus_req.bus_tx), 128'(GETS));
    check("s1_bcast_busy", 128'(bus_if.busy), 128'(1'b1));
    set_req(3, 1'b0, GETS, 32'h100);
    step();
    step();
    set_resp(1'b1, 32'h100);
    step();
    set_resp(1'b0, 32'h0);
    check("s1_resp_valid", 128'(bus_if.bus_resp.valid), 128'(1'b1));
    check("s1_busy_low", 128'(bus_if.busy), 128'(1'b0));

    // All caches requesting continuously, immediate responses
    reset_pulse();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, GETM, 32'h1000 + 32'(i) * 32'h10);
    for (int g = 0; g <= 8; g++) begin
      step();
      check("s2_rr_order", 128'(obs_ready), 128'(onehot(g % 8)));
      step();
      set_resp(1'b1, 32'h1000 + 32'(g % 8) * 32'h10);
      step();
      set_resp(1'b0, 32'h0);
    end

    // Pointer at 6 with only cache 2 requesting wraps to 2, then pointer is 3
    reset_pulse();
    run_txn(5, 32'h500, "s3_grant5");
    run_txn(2, 32'h200, "s3_wrap2");
    for (int i = 0; i < N; i++) set_req(i, 1'b1, GETS, 32'h3000 + 32'(i) * 32'h10);
    step();
    check("s3_ptr_after_wrap", 128'(obs_ready), 128'(8'b0000_1000));
    for (int i = 0; i < N; i++) set_req(i, 1'b0, GETS, 32'h0);
    step();
    set_resp(1'b1, 32'h3030);
    step();
    set_resp(1'b0, 32'h0);

    // Non-matching response is forwarded but does not complete
    set_req(0, 1'b1, GETS, 32'h100);
    step();
    set_req(0, 1'b0, GETS, 32'h100);
    step();
    set_resp(1'b1, 32'h200);
    step();
    set_resp(1'b0, 32'h0);
    check("s4_fwd_valid", 128'(bus_if.bus_resp.valid), 128'(1'b1));
    check("s4_fwd_addr", 128'(bus_if.bus_resp.addr), 128'(32'h200));
    check("s4_still_busy", 128'(bus_if.busy), 128'(1'b1));
    step();
    set_resp(1'b1, 32'h100);
    step();
    set_resp(1'b0, 32'h0);
    check("s4_done", 128'(bus_if.busy), 128'(1'b0));

    // No response: exactly one timeout pulse after TO wait cycles
    set_req(4, 1'b1, GETS, 32'h400);
    step();
    set_req(4, 1'b0, GETS, 32'h400);
    pulses = 0;
    first  = -1;
    for (int c = 1; c <= TO + 8; c++) begin
      step();
      if (bus_if.timeout_err) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    check("s5_pulses", 128'(pulses), 128'(1));
    check("s5_pulse_cycle", 128'(first), 128'(TO + 1));
    check("s5_idle", 128'(bus_if.busy), 128'(1'b0));

    // Response in the last permitted wait cycle completes without error
    set_req(4, 1'b1, GETS, 32'h440);
    step();
    set_req(4, 1'b0, GETS, 32'h440);
    step();
    repeat (TO - 1) step();
    set_resp(1'b1, 32'h440);
    step();
    set_resp(1'b0, 32'h0);
    check("s5_limit_no_err", 128'(bus_if.timeout_err), 128'(1'b0));
    check("s5_limit_idle", 128'(bus_if.busy), 128'(1'b0));
    step();
    check("s5_limit_no_err_late", 128'(bus_if.timeout_err), 128'(1'b0));

    // Reset while waiting abandons the transaction; pending caches restart from index 0
    set_req(1, 1'b1, GETS, 32'h110);
    step();
    set_req(1, 1'b0, GETS, 32'h110);
    step();
    step();
    set_resp(1'b1, 32'h999);
    rst = 1'b1;
    step();
    set_resp(1'b0, 32'h0);
    set_req(5, 1'b1, GETS, 32'h550);
    set_req(7, 1'b1, GETM, 32'h770);
    #1;
    check("s6_rst_ready", 128'(bus_if.req_ready), 128'(0));
    check("s6_rst_bus_req", 128'(bus_if.bus_req), 128'(0));
    check("s6_rst_bus_resp", 128'(bus_if.bus_resp), 128'(0));
    check("s6_rst_busy", 128'(bus_if.busy), 128'(1'b0));
    check("s6_rst_err", 128'(bus_if.timeout_err), 128'(1'b0));
    rst = 1'b0;
    step();
    check("s6_grant5", 128'(obs_ready), 128'(8'b0010_0000));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      for (int i = 0; i < N; i++) begin
        if (i == last_grant)
          set_req(i, ($urandom_range(0, 3) == 0), bus_tx_t'(2'($urandom_range(0, 3))), rand_addr());
        else if (!bus_if.req_msg[IW'(i)].valid && $urandom_range(0, 3) == 0)
          set_req(i, 1'b1, bus_tx_t'(2'($urandom_range(0, 3))), rand_addr());
      end
      if (m_busy && m_age >= 2) begin
        r = int'($urandom_range(0, 9));
        if (r < 2)      set_resp(1'b1, m_lat.addr);
        else if (r < 4) set_resp(1'b1, m_lat.addr ^ 32'h10);
        else            set_resp(1'b0, rand_addr());
      end else begin
        set_resp($urandom_range(0, 7) == 0, rand_addr());
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coherence_bus_arbiter.md
COHERENCE_BUS_ARBITER -- requirements
Module: coherence_bus_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default NUM_CACHE (8), the number of cache requesters sharing the snoop bus.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of WAIT cycles before the transaction is aborted.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port req_msg, input, NUM_REQ x req_msg_t, per-cache request; .valid marks a pending request.
REQ-006 The block SHALL have port req_ready, output, NUM_REQ, one-hot accept pulse to the granted cache.
REQ-007 The block SHALL have port bus_req, output, req_msg_t, the registered broadcast request seen by all caches and memory.
REQ-008 The block SHALL have port resp_in, input, resp_msg_t, the response from the owner cache or memory.
REQ-009 The block SHALL have port bus_resp, output, resp_msg_t, the registered response forwarded to all caches.
REQ-010 The block SHALL have port busy, output, 1, high while a transaction is outstanding.
REQ-011 The block SHALL have port timeout_err, output, 1, a one-cycle pulse on abort.

Function
REQ-012 The FSM SHALL have three states: ARB_IDLE, ARB_BCAST and ARB_WAIT.
REQ-013 In ARB_IDLE with any req_msg[i].valid, the block SHALL select the winner round-robin starting at pointer rr_ptr, pulse req_ready[winner] that cycle, latch req_msg[winner], and go to ARB_BCAST.
REQ-014 With no request in ARB_IDLE, the block SHALL hold all req_ready low and stay in ARB_IDLE.
REQ-015 After a grant to i, rr_ptr SHALL become (i+1) mod NUM_REQ, wrapping NUM_REQ-1 to 0; rr_ptr SHALL change only on a grant.
REQ-016 In ARB_BCAST, bus_req SHALL present the latched message with valid=1 and source=winner index (width $clog2(NUM_CACHE)+1, zero-extended) for exactly one cycle; the FSM SHALL then go to ARB_WAIT.
REQ-017 Outside ARB_BCAST, bus_req.valid SHALL be 0; the other bus_req fields are don't-care.
REQ-018 In ARB_WAIT, a transaction SHALL complete on resp_in.valid && resp_in.addr == latched addr; the FSM SHALL then return to ARB_IDLE.
REQ-019 A resp_in with valid=1 whose addr does not match SHALL be ignored for completion but still forwarded.
REQ-020 bus_resp SHALL equal resp_in delayed by one cycle in every state.
REQ-021 Grant latency SHALL be: grant at T, broadcast at T+1, earliest completion at T+2, earliest next grant at T+3.
REQ-022 The bus SHALL be atomic: exactly one transaction is outstanding, from grant to completion.
REQ-023 A requester SHALL hold its valid and its fields stable until req_ready; the block SHALL sample them only in the grant cycle.
REQ-024 A wait counter SHALL clear on entry to ARB_WAIT and increment each ARB_WAIT cycle.
REQ-025 When the counter reaches TIMEOUT_CYCLES without completion, the block SHALL pulse timeout_err for one cycle and return to ARB_IDLE.
REQ-026 A matching response arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL complete normally with no timeout_err.
REQ-027 busy SHALL be 1 in ARB_BCAST and ARB_WAIT and 0 in ARB_IDLE.

Reset
REQ-028 On rst, the block SHALL set: state=ARB_IDLE, rr_ptr=0, wait counter=0, req_ready=0, bus_req=0, bus_resp=0, busy=0, timeout_err=0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction with no completion or error pulse; the first grant after deassertion SHALL go to the lowest valid index at or after 0.

Structure
REQ-030 The arbiter state enum (ARB_IDLE, ARB_BCAST, ARB_WAIT) SHALL be added to the shared cache_types package; req_msg_t, resp_msg_t and NUM_CACHE SHALL be reused from that package.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector and pointer; outputs: one-hot grant and index), combinational and parameterized by NUM_REQ.

Verification
REQ-032 Scenario: reset, then req 3 valid GETS addr 0x100 -> req_ready[3] at T, bus_req.valid/source=3/bus_tx=GETS at T+1, resp addr 0x100 at T+3 -> bus_resp valid at T+4, busy low at T+4.
REQ-033 Scenario: all 8 valid continuously with immediate responses -> grant order 0,1,2,...,7,0 with no repeats.
REQ-034 Scenario: rr_ptr=6 and only req 2 valid -> req 2 granted (wrap) and rr_ptr becomes 3.
REQ-035 Scenario: resp addr 0x200 while waiting on 0x100 -> forwarded on bus_resp, FSM stays in ARB_WAIT, then completes on 0x100.
REQ-036 Scenario: no response for TIMEOUT_CYCLES -> single timeout_err pulse and return to idle; a response at exactly the limit -> no error.
REQ-037 Scenario: rst asserted during ARB_WAIT -> all outputs zero the next cycle; req 5 pending afterwards is granted normally.
